synapse_weight_updater: RTL and testbench
=========================================

Name: synapse_weight_updater

Overview:
- Downstream consumer of the STDP learning engine's signed 8-bit delta_w.
- Applies each delta to one entry of a small on-chip synaptic weight register file, using an FSM-sequenced read-modify-write with saturation.
- Exposes a registered read port so the neuron core can fetch current weights.
- Counts clipped updates for diagnostics.

Parameters:
- NUM_SYN, 16, number of synapses / weight entries (power of 2, ≥2)
- ADDR_W, 4, address width, equals log2(NUM_SYN)
- WEIGHT_W, 8, signed weight width
- W_MIN, 0, lower saturation bound (signed)
- W_MAX, 100, upper saturation bound (signed, W_MAX ≥ W_MIN)
- INIT_W, 50, reset value of every weight (W_MIN ≤ INIT_W ≤ W_MAX)

Ports:
- clk, input, 1, system clock, rising edge
- rst, input, 1, asynchronous active-high reset
- learn_en, input, 1, global learning enable; gates acceptance only
- upd_valid, input, 1, update request valid
- upd_ready, output, 1, unit can accept a request
- upd_addr, input, ADDR_W, target synapse index
- delta_w, input, 8 signed, weight change from the learning engine
- upd_done, output, 1, one-cycle pulse when a weight is committed
- upd_sat, output, 1, qualifies upd_done; the committed value was clipped
- rd_addr, input, ADDR_W, read address
- rd_data, output, WEIGHT_W signed, registered weight at rd_addr
- sat_count, output, 16, saturating count of clipped updates

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values:
  - all weights = INIT_W
  - FSM = IDLE
  - upd_ready = 1 once rst deasserts
  - upd_done = 0, upd_sat = 0, rd_data = 0, sat_count = 0
- FSM states: IDLE, CALC, WRITE.
  - upd_ready = (state == IDLE) && learn_en.
- IDLE:
  - On upd_valid && upd_ready: latch upd_addr and delta_w; go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Compute sum = weight[addr] + sign-extended delta at WEIGHT_W+2 bits signed; no overflow is possible at this width.
  - If sum > W_MAX, the result is W_MAX. If sum < W_MIN, the result is W_MIN. Otherwise the result is sum.
  - Register the result and the clip flag; go to WRITE.
- WRITE:
  - Write the result to weight[addr].
  - Pulse upd_done for exactly this one cycle; upd_sat = clip flag in the same cycle.
  - If the clip flag is set and sat_count < 16'hFFFF, increment sat_count.
  - Go to IDLE.
- Latency and throughput:
  - Acceptance edge → upd_done asserted 2 cycles later.
  - Weight visible on the read port the cycle after WRITE.
  - Maximum throughput is one update per 3 cycles.
- delta_w = 0: full RMW still runs; upd_done pulses; weight unchanged; upd_sat = 0 (unless INIT_W is out of range, which is disallowed).
- learn_en:
  - Deasserting learn_en mid-operation does not abort; CALC/WRITE complete normally.
  - Only new acceptance is blocked.
- Request stability: upd_valid held while upd_ready = 0 is not consumed. The requester must keep addr/delta stable until the handshake.
- Read port:
  - rd_data <= weight[rd_addr] on every rising edge, 1-cycle latency, independent of the FSM.
  - Reading the address being written in WRITE returns the old value that cycle and the new value the next cycle. No bypass.
- Reset mid-operation: any state returns to IDLE; the in-flight update is discarded; all weights reinitialised to INIT_W.
- sat_count: holds at 16'hFFFF; never wraps.
- Address range: NUM_SYN is a power of 2, so every address is valid and no wrap logic is needed.

Test Plan:
- Reset, then read all 16 addresses → rd_data = 50 each, one cycle after each rd_addr; upd_ready = 1, sat_count = 0.
- learn_en = 1, upd addr 3, delta +2 → upd_done 2 cycles after acceptance, upd_sat = 0; read addr 3 → 52; upd_ready low for exactly 2 cycles.
- addr 5, delta −1 applied 51 times back-to-back → weight 0. The 51st update gives upd_sat = 1 and sat_count = 1. A further −1 gives weight 0 and sat_count = 2.
- addr 7, delta +127 → weight 100 (clipped), upd_sat = 1. Then delta −128 at addr 7 → weight 0, upd_sat = 1.
- learn_en = 0 with upd_valid held → upd_ready = 0, no upd_done, weights unchanged. Drop learn_en during CALC → that update still commits.
- Assert rst during CALC of addr 2 (delta +2) → no upd_done, FSM in IDLE, addr 2 reads 50. Same-cycle read of the WRITE address returns the old then the new value.

Source files
------------

// File: rtl/synapse_weight_updater.sv
// Synaptic weight register file updated by saturating read-modify-write.
// Registered read port and a saturating clipped-update counter.
module synapse_weight_updater #(
  parameter int NUM_SYN  = 16,
  parameter int ADDR_W   = 4,
  parameter int WEIGHT_W = 8,
  parameter int W_MIN    = 0,
  parameter int W_MAX    = 100,
  parameter int INIT_W   = 50
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       learn_en,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [ADDR_W-1:0]          upd_addr,
  input  logic signed [7:0]          delta_w,
  output logic                       upd_done,
  output logic                       upd_sat,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic signed [WEIGHT_W-1:0] rd_data,
  output logic [15:0]                sat_count
);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  localparam int SW = WEIGHT_W + 2;
  localparam logic signed [SW-1:0] MAX_X = SW'(W_MAX);
  localparam logic signed [SW-1:0] MIN_X = SW'(W_MIN);
  localparam logic signed [WEIGHT_W-1:0] INIT_C = WEIGHT_W'(INIT_W);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic signed [7:0] delta_q, delta_d;
  logic signed [WEIGHT_W-1:0] res_q, res_d;
  logic clip_q, clip_d;
  logic done_q, done_d;
  logic sat_q, sat_d;
  logic [15:0] cnt_q, cnt_d;
  logic signed [WEIGHT_W-1:0] rd_q, rd_d;
  logic signed [WEIGHT_W-1:0] w_q [NUM_SYN];
  logic signed [WEIGHT_W-1:0] w_d [NUM_SYN];
  logic signed [SW-1:0] sum;

  assign upd_ready = (state_q == IDLE) && learn_en;
  assign upd_done  = done_q;
  assign upd_sat   = sat_q;
  assign rd_data   = rd_q;
  assign sat_count = cnt_q;

  // Two guard bits make the sum exact for any weight/delta pair
  assign sum = SW'(w_q[addr_q]) + SW'(delta_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    delta_d = delta_q;
    res_d   = res_q;
    clip_d  = clip_q;
    done_d  = 1'b0;
    sat_d   = 1'b0;
    cnt_d   = cnt_q;
    w_d     = w_q;
    rd_d    = w_q[rd_addr];
    unique case (state_q)
      IDLE: begin
        if (upd_valid && upd_ready) begin
          addr_d  = upd_addr;
          delta_d = delta_w;
          state_d = CALC;
        end
      end
      CALC: begin
        if (sum > MAX_X) begin
          res_d  = MAX_X[WEIGHT_W-1:0];
          clip_d = 1'b1;
        end else if (sum < MIN_X) begin
          res_d  = MIN_X[WEIGHT_W-1:0];
          clip_d = 1'b1;
        end else begin
          res_d  = sum[WEIGHT_W-1:0];
          clip_d = 1'b0;
        end
        state_d = WRITE;
      end
      WRITE: begin
        w_d[addr_q] = res_q;
        done_d      = 1'b1;
        sat_d       = clip_q;
        if (clip_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      delta_q <= '0;
      res_q   <= '0;
      clip_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < NUM_SYN; i++) w_q[i] <= INIT_C;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      delta_q <= delta_d;
      res_q   <= res_d;
      clip_q  <= clip_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      w_q     <= w_d;
    end
  end

endmodule

// File: tb/tb_synapse_weight_updater.sv
// Randomized bench for synapse_weight_updater against an arithmetic
// model of the weight table and clip counter.
module tb_synapse_weight_updater;

  logic clk = 0;
  logic rst = 1;
  logic learn_en = 0;
  logic upd_valid = 0;
  logic upd_ready;
  logic [3:0] upd_addr = '0;
  logic signed [7:0] delta_w = '0;
  logic upd_done;
  logic upd_sat;
  logic [3:0] rd_addr = '0;
  logic signed [7:0] rd_data;
  logic [15:0] sat_count;

  int n_cmp = 0;
  int n_err = 0;
  int mw [16];
  int msat = 0;

  synapse_weight_updater dut (
    .clk(clk), .rst(rst), .learn_en(learn_en),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_addr(upd_addr), .delta_w(delta_w),
    .upd_done(upd_done), .upd_sat(upd_sat),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mw[i] = 50;
    msat = 0;
  endfunction

  function automatic bit model_upd(input int a, input int d);
    int s;
    bit c;
    s = mw[a] + d;
    c = (s > 100) || (s < 0);
    mw[a] = (s > 100) ? 100 : ((s < 0) ? 0 : s);
    if (c && msat < 65535) msat++;
    return c;
  endfunction

  task automatic rd(input logic [3:0] a, output logic signed [7:0] v);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic apply(input logic [3:0] a, input logic signed [7:0] d,
                       output int lat, output logic sat,
                       output int ndone, output logic [5:0] rdy);
    int n;
    n = 0;
    @(negedge clk);
    upd_addr = a;
    delta_w = d;
    upd_valid = 1;
    while (!upd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (upd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout ready=%b required=1", upd_ready);
    end
    @(posedge clk);
    lat = -1; sat = 0; ndone = 0; rdy = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) upd_valid = 0;
      rdy[k] = upd_ready;
      if (upd_done === 1'b1) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          sat = upd_sat;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic signed [7:0] v;
    rst = 1;
    learn_en = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    n_cmp++;
    if (upd_ready !== 1'b1 || sat_count !== 16'd0 || upd_done !== 1'b0 ||
        upd_sat !== 1'b0 || rd_data !== 8'sd0) begin
      n_err++;
      $display("FAIL reset_state rdy=%b cnt=%0d done=%b sat=%b rd=%0d required 1/0/0/0/0",
               upd_ready, sat_count, upd_done, upd_sat, rd_data);
    end
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      n_cmp++;
      if (v !== 8'(mw[i])) begin
        n_err++;
        $display("FAIL reset_weight[%0d] got=%0d required=%0d", i, v, mw[i]);
      end
    end
  endtask

  task automatic test_single();
    int lat, nd;
    logic sat;
    logic [5:0] rdy;
    logic signed [7:0] v;
    bit c;
    c = model_upd(3, 2);
    apply(4'd3, 8'sd2, lat, sat, nd, rdy);
    n_cmp++;
    if (lat !== 2 || sat !== c || nd !== 1) begin
      n_err++;
      $display("FAIL single_done lat=%0d sat=%b pulses=%0d required 2/%b/1", lat, sat, nd, c);
    end
    n_cmp++;
    if (rdy[2:0] !== 3'b100) begin
      n_err++;
      $display("FAIL single_ready_window got=%b required=100", rdy[2:0]);
    end
    rd(4'd3, v);
    n_cmp++;
    if (v !== 8'(mw[3])) begin
      n_err++;
      $display("FAIL single_weight got=%0d required=%0d", v, mw[3]);
    end
  endtask

  task automatic test_sat_low();
    int lat, nd;
    logic sat;
    logic [5:0] rdy;
    logic signed [7:0] v;
    bit c;
    for (int i = 0; i < 52; i++) begin
      c = model_upd(5, -1);
      apply(4'd5, -8'sd1, lat, sat, nd, rdy);
      n_cmp++;
      if (lat !== 2 || sat !== c) begin
        n_err++;
        $display("FAIL sat_low_step%0d lat=%0d sat=%b required 2/%b", i, lat, sat, c);
      end
      if (i == 50) begin
        n_cmp++;
        if (sat_count !== 16'(msat) || msat != 1) begin
          n_err++;
          $display("FAIL sat_low_count1 got=%0d required=1", sat_count);
        end
      end
    end
    rd(4'd5, v);
    n_cmp++;
    if (v !== 8'sd0 || sat_count !== 16'd2) begin
      n_err++;
      $display("FAIL sat_low_final w=%0d cnt=%0d required 0/2", v, sat_count);
    end
  endtask

  task automatic test_sat_high();
    int lat, nd;
    logic sat;
    logic [5:0] rdy;
    logic signed [7:0] v;
    bit c;
    c = model_upd(7, 127);
    apply(4'd7, 8'sd127, lat, sat, nd, rdy);
    rd(4'd7, v);
    n_cmp++;
    if (sat !== 1'b1 || c != 1 || v !== 8'sd100) begin
      n_err++;
      $display("FAIL sat_high_plus sat=%b w=%0d required 1/100", sat, v);
    end
    c = model_upd(7, -128);
    apply(4'd7, 8'sh80, lat, sat, nd, rdy);
    rd(4'd7, v);
    n_cmp++;
    if (sat !== 1'b1 || c != 1 || v !== 8'sd0) begin
      n_err++;
      $display("FAIL sat_high_minus sat=%b w=%0d required 1/0", sat, v);
    end
    n_cmp++;
    if (sat_count !== 16'(msat)) begin
      n_err++;
      $display("FAIL sat_high_count got=%0d required=%0d", sat_count, msat);
    end
  endtask

  task automatic test_learn_en();
    logic signed [7:0] v;
    bit c;
    @(negedge clk);
    learn_en = 0;
    upd_addr = 4'd1;
    delta_w = 8'sd10;
    upd_valid = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (upd_ready !== 1'b0 || upd_done !== 1'b0) begin
        n_err++;
        $display("FAIL learn_gate_c%0d rdy=%b done=%b required 0/0", k, upd_ready, upd_done);
      end
    end
    rd(4'd1, v);
    n_cmp++;
    if (v !== 8'(mw[1])) begin
      n_err++;
      $display("FAIL learn_gate_weight got=%0d required=%0d", v, mw[1]);
    end
    learn_en = 1;
    c = model_upd(1, 10);
    @(posedge clk);
    @(negedge clk);
    learn_en = 0;
    upd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (upd_done !== 1'b1 || upd_sat !== c) begin
      n_err++;
      $display("FAIL learn_drop_commit done=%b sat=%b required 1/%b", upd_done, upd_sat, c);
    end
    rd(4'd1, v);
    n_cmp++;
    if (v !== 8'(mw[1])) begin
      n_err++;
      $display("FAIL learn_drop_weight got=%0d required=%0d", v, mw[1]);
    end
    learn_en = 1;
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] v;
    bit c;
    @(negedge clk);
    upd_addr = 4'd9;
    delta_w = 8'sd1;
    upd_valid = 1;
    for (int i = 0; i < 4; i++) c = model_upd(9, 1);
    @(posedge clk);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 9) upd_valid = 0;
      n_cmp++;
      if (upd_done !== ((k % 3 == 2) && k <= 11)) begin
        n_err++;
        $display("FAIL b2b_done_c%0d got=%b", k, upd_done);
      end
    end
    rd(4'd9, v);
    n_cmp++;
    if (v !== 8'(mw[9])) begin
      n_err++;
      $display("FAIL b2b_weight got=%0d required=%0d", v, mw[9]);
    end
  endtask

  task automatic test_read_during_write();
    int oldw;
    bit c;
    oldw = mw[4];
    c = model_upd(4, 5);
    @(negedge clk);
    rd_addr = 4'd4;
    upd_addr = 4'd4;
    delta_w = 8'sd5;
    upd_valid = 1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) upd_valid = 0;
      if (k == 2) begin
        n_cmp++;
        if (upd_done !== 1'b1 || rd_data !== 8'(oldw)) begin
          n_err++;
          $display("FAIL rdw_old done=%b rd=%0d required 1/%0d", upd_done, rd_data, oldw);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (rd_data !== 8'(mw[4])) begin
          n_err++;
          $display("FAIL rdw_new rd=%0d required=%0d", rd_data, mw[4]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic signed [7:0] v;
    @(negedge clk);
    upd_addr = 4'd2;
    delta_w = 8'sd2;
    upd_valid = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    upd_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (upd_done !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_done_c%0d got=%b required=0", k, upd_done);
      end
    end
    rst = 0;
    model_reset();
    n_cmp++;
    if (upd_ready !== 1'b1 || sat_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid_state rdy=%b cnt=%0d required 1/0", upd_ready, sat_count);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (upd_done !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_after_c%0d done=%b required=0", k, upd_done);
      end
    end
    rd(4'd2, v);
    n_cmp++;
    if (v !== 8'(mw[2])) begin
      n_err++;
      $display("FAIL rst_mid_w2 got=%0d required=%0d", v, mw[2]);
    end
    rd(4'd5, v);
    n_cmp++;
    if (v !== 8'(mw[5])) begin
      n_err++;
      $display("FAIL rst_mid_w5 got=%0d required=%0d", v, mw[5]);
    end
  endtask

  task automatic test_random();
    int lat, nd;
    logic sat;
    logic [5:0] rdy;
    logic signed [7:0] v;
    logic [3:0] a;
    logic signed [7:0] d;
    bit c;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      c = model_upd(int'(a), int'(d));
      apply(a, d, lat, sat, nd, rdy);
      n_cmp++;
      if (lat !== 2 || sat !== c || nd !== 1) begin
        n_err++;
        $display("FAIL rand%0d_done a=%0d d=%0d lat=%0d sat=%b n=%0d required 2/%b/1",
                 i, a, d, lat, sat, nd, c);
      end
      a = 4'($urandom_range(0, 15));
      rd(a, v);
      n_cmp++;
      if (v !== 8'(mw[a])) begin
        n_err++;
        $display("FAIL rand%0d_read a=%0d got=%0d required=%0d", i, a, v, mw[a]);
      end
    end
    n_cmp++;
    if (sat_count !== 16'(msat)) begin
      n_err++;
      $display("FAIL rand_count got=%0d required=%0d", sat_count, msat);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sat_low();
    test_sat_high();
    test_learn_en();
    test_back_to_back();
    test_read_during_write();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
